oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 16 +
 rtl/oam_dma.sv | 116 +++++++++++
 tb/tb_oam_dma.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared CPU package: DMA state type and the fixed addresses and lengths
// the OAM DMA engine is built around.
package oam_dma_pkg;

  typedef enum logic [1:0] {
    DmaIdle,
    DmaStart,
    DmaActive
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int unsigned DMA_LEN      = 160;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
  localparam logic [7:0]  LAST_INDEX   = 8'(DMA_LEN - 1);

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies 160 bytes from {src_hi, 00..9F} into OAM, one byte
// per M-cycle, sharing the system bus with the CPU. The CPU keeps the bus for
// high-page (0xFF00+) accesses; any other M-cycle during a transfer belongs
// to the DMA and the CPU is locked out (reads see 0xFF, writes are dropped).
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  dma_state_e state_reg, state_next;
  logic [7:0] index_reg, index_next;
  logic [7:0] src_hi_reg, src_hi_next;
  logic       owner_dma_reg;
  logic       owner_dma_sample;
  logic       owner_dma;
  logic       last_t;
  logic       reg_hit;
  logic       reg_write;

  assign last_t    = (t_cycle == 2'd3);
  assign reg_hit   = cpu_enable && (cpu_addr == DMA_REG_ADDR);
  assign reg_write = reg_hit && cpu_write && last_t;

  // The DMA owns an M-cycle only while transferring and the CPU is not
  // touching the high page. The decision is taken at T0 and held to T3; at
  // T0 itself the fresh value is used so ownership covers the whole M-cycle.
  assign owner_dma_sample = (state_reg == DmaActive) &&
                            !(cpu_enable && (cpu_addr[15:8] == HIGH_PAGE));
  assign owner_dma = reset_n &&
                     ((t_cycle == 2'd0) ? owner_dma_sample : owner_dma_reg);

  assign dma_active = (state_reg != DmaIdle);

  // State, index, source page and ownership registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= DmaIdle;
      index_reg     <= 8'h00;
      src_hi_reg    <= 8'h00;
      owner_dma_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      src_hi_reg <= src_hi_next;
      if (t_cycle == 2'd0) begin
        owner_dma_reg <= owner_dma_sample;
      end
    end
  end

  // Next state: a DMA register write restarts from any state and wins over
  // the last-byte completion; everything else moves only at T3.
  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    src_hi_next = src_hi_reg;
    if (reg_write) begin
      src_hi_next = cpu_wdata;
      state_next  = DmaStart;
      index_next  = 8'h00;
    end else if (last_t) begin
      case (state_reg)
        DmaStart: state_next = DmaActive;
        DmaActive: begin
          if (owner_dma) begin
            if (index_reg == LAST_INDEX) begin
              state_next = DmaIdle;
              index_next = 8'h00;
            end else begin
              index_next = index_reg + 8'd1;
            end
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Bus mux: CPU pass-through by default, DMA read + OAM write when owned.
  always_comb begin
    bus_addr   = cpu_addr;
    bus_enable = cpu_enable;
    bus_write  = cpu_write;
    bus_wdata  = cpu_wdata;
    cpu_rdata  = reg_hit ? src_hi_reg : bus_rdata;
    oam_write  = 1'b0;
    oam_addr   = index_reg;
    oam_wdata  = bus_rdata;
    if (owner_dma) begin
      bus_addr   = {src_hi_reg, index_reg};
      bus_enable = 1'b1;
      bus_write  = 1'b0;
      bus_wdata  = 8'h00;
      cpu_rdata  = 8'hFF;
      oam_write  = last_t;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: M-cycle level reference model of the DMA transfer,
// directed scenarios plus a randomized CPU traffic run.
module tb_oam_dma;
  import oam_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  t_cycle = 2'd0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_enable = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_enable;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_addr;
  logic        oam_write;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] salt = 8'h00;

  always #5 clk = ~clk;

  // Memory contents seen on the system bus: a fixed scramble of the address.
  assign bus_rdata = bus_addr[15:8] ^ (bus_addr[7:0] * 8'd3) ^ salt;

  oam_dma dut (
    .clk(clk), .reset_n(reset_n), .t_cycle(t_cycle),
    .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  // Reference model: 0 = idle, 1 = start pending, 2 = transferring.
  int         m_phase = 0;
  logic [7:0] m_idx = 8'h00;
  logic [7:0] m_src = 8'h00;
  logic [7:0] oam_shadow [0:159];

  // Observations from the most recent M-cycle.
  logic [15:0] obs_bus_addr;
  logic [7:0]  obs_rdata;
  logic [7:0]  obs_oam_addr;
  logic        obs_dma_active;
  logic        obs_oam_write_any;
  logic        obs_bus_write_any;
  logic        obs_active_low;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[15:8] ^ (a[7:0] * 8'd3) ^ salt;
  endfunction

  // Drive one M-cycle of CPU activity and check every T-cycle against the model.
  task automatic run_m(input logic rst, input logic en, input logic we,
                       input logic [15:0] addr, input logic [7:0] wd);
    logic        owns;
    logic [15:0] e_addr;
    logic        e_en, e_we, e_act, e_ow;
    logic [7:0]  e_rd;
    owns = !rst && (m_phase == 2) && !(en && addr[15:8] == 8'hFF);
    obs_oam_write_any = 1'b0;
    obs_bus_write_any = 1'b0;
    obs_active_low    = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (t == 0) begin
        reset_n = !rst; cpu_enable = en; cpu_write = we;
        cpu_addr = addr; cpu_wdata = wd;
      end
      t_cycle = 2'(t);
      #1;
      if (owns) begin e_addr = {m_src, m_idx}; e_en = 1'b1; e_we = 1'b0; end
      else begin e_addr = addr; e_en = en; e_we = we; end
      n_vec++;
      if ({bus_addr, bus_enable, bus_write} !== {e_addr, e_en, e_we}) begin
        n_err++;
        $display("FAIL bus_ctl t%0d: got addr=%h en=%b we=%b, want addr=%h en=%b we=%b",
                 t, bus_addr, bus_enable, bus_write, e_addr, e_en, e_we);
      end
      if (!owns) begin
        n_vec++;
        if (bus_wdata !== wd) begin
          n_err++;
          $display("FAIL bus_wdata t%0d: got %h want %h", t, bus_wdata, wd);
        end
      end
      if (en && !we && !(rst && addr == 16'hFF46)) begin
        e_rd = owns ? 8'hFF : ((addr == 16'hFF46) ? m_src : mem_byte(addr));
        n_vec++;
        if (cpu_rdata !== e_rd) begin
          n_err++;
          $display("FAIL cpu_rdata t%0d addr=%h: got %h want %h", t, addr, cpu_rdata, e_rd);
        end
      end
      e_ow = owns && (t == 3);
      n_vec++;
      if (oam_write !== e_ow) begin
        n_err++;
        $display("FAIL oam_write t%0d: got %b want %b", t, oam_write, e_ow);
      end
      if (e_ow) begin
        n_vec++;
        if ({oam_addr, oam_wdata} !== {m_idx, mem_byte({m_src, m_idx})}) begin
          n_err++;
          $display("FAIL oam_data: got addr=%h data=%h want addr=%h data=%h",
                   oam_addr, oam_wdata, m_idx, mem_byte({m_src, m_idx}));
        end
        oam_shadow[m_idx] = oam_wdata;
      end
      if (!(rst && t == 0)) begin
        e_act = rst ? 1'b0 : (m_phase != 0);
        n_vec++;
        if (dma_active !== e_act) begin
          n_err++;
          $display("FAIL dma_active t%0d: got %b want %b", t, dma_active, e_act);
        end
      end
      if (oam_write === 1'b1) begin
        obs_oam_write_any = 1'b1;
        obs_oam_addr = oam_addr;
      end
      if (bus_write === 1'b1) obs_bus_write_any = 1'b1;
      if (dma_active !== 1'b1) obs_active_low = 1'b1;
      if (t == 3) begin
        obs_bus_addr   = bus_addr;
        obs_rdata      = cpu_rdata;
        obs_dma_active = dma_active;
      end
    end
    if (rst) begin
      m_phase = 0; m_idx = 8'h00; m_src = 8'h00;
    end else if (en && we && addr == 16'hFF46) begin
      m_src = wd; m_phase = 1; m_idx = 8'h00;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (owns) begin
      if (m_idx == 8'd159) begin m_phase = 0; m_idx = 8'h00; end
      else m_idx = m_idx + 8'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_m(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_reset;
    run_m(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
    run_m(1'b1, 1'b1, 1'b1, 16'hC000, 8'h77);
    run_m(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);
    n_vec++;
    if (obs_rdata !== 8'h00 || obs_dma_active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got ff46=%h active=%b want 00/0", obs_rdata, obs_dma_active);
    end
    $display("test_reset done");
  endtask

  task automatic test_nominal;
    int bad;
    for (int i = 0; i < 160; i++) oam_shadow[i] = ~mem_byte({8'hC1, 8'(i)});
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'hC1);              // M0
    idle(1);                                               // M1
    n_vec++;
    if (obs_dma_active !== 1'b1 || obs_oam_write_any !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_start: got active=%b ow=%b want 1/0", obs_dma_active, obs_oam_write_any);
    end
    idle(1);                                               // M2
    n_vec++;
    if (obs_bus_addr !== 16'hC100 || obs_oam_write_any !== 1'b1 || obs_oam_addr !== 8'h00) begin
      n_err++;
      $display("FAIL nominal_first: got addr=%h ow=%b oam_addr=%h want c100/1/00",
               obs_bus_addr, obs_oam_write_any, obs_oam_addr);
    end
    idle(159);                                             // M3..M161
    n_vec++;
    if (obs_bus_addr !== 16'hC19F || obs_oam_addr !== 8'h9F) begin
      n_err++;
      $display("FAIL nominal_last: got addr=%h oam_addr=%h want c19f/9f", obs_bus_addr, obs_oam_addr);
    end
    idle(1);                                               // M162
    n_vec++;
    if (obs_dma_active !== 1'b0 || obs_oam_write_any !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_end: got active=%b ow=%b want 0/0", obs_dma_active, obs_oam_write_any);
    end
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (oam_shadow[i] !== mem_byte({8'hC1, 8'(i)})) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL nominal_oam_image: got %0d wrong bytes want 0", bad);
    end
    $display("test_nominal done");
  endtask

  task automatic test_blocking;
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'h3A);              // M0
    idle(3);                                               // M1..M3
    run_m(1'b0, 1'b1, 1'b0, 16'h8000, 8'h00);              // M4, index 2
    n_vec++;
    if (obs_rdata !== 8'hFF || obs_bus_addr !== 16'h3A02) begin
      n_err++;
      $display("FAIL blocked_read: got rdata=%h addr=%h want ff/3a02", obs_rdata, obs_bus_addr);
    end
    run_m(1'b0, 1'b1, 1'b1, 16'hC000, 8'h55);              // M5, index 3
    n_vec++;
    if (obs_bus_write_any !== 1'b0 || obs_bus_addr !== 16'h3A03) begin
      n_err++;
      $display("FAIL blocked_write: got we=%b addr=%h want 0/3a03", obs_bus_write_any, obs_bus_addr);
    end
    idle(160);
    $display("test_blocking done");
  endtask

  task automatic test_high_stall;
    logic [7:0] src;
    int end_m;
    src = 8'($urandom_range(0, 255));
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, src);                // M0
    idle(11);                                              // M1..M11
    run_m(1'b0, 1'b1, 1'b0, 16'hFF80, 8'h00);              // M12, index 10 pending
    n_vec++;
    if (obs_bus_addr !== 16'hFF80 || obs_oam_write_any !== 1'b0) begin
      n_err++;
      $display("FAIL stall_cycle: got addr=%h ow=%b want ff80/0", obs_bus_addr, obs_oam_write_any);
    end
    idle(1);                                               // M13
    n_vec++;
    if (obs_oam_write_any !== 1'b1 || obs_oam_addr !== 8'd10 || obs_bus_addr !== {src, 8'd10}) begin
      n_err++;
      $display("FAIL stall_resume: got ow=%b oam_addr=%h addr=%h want 1/0a/%h0a",
               obs_oam_write_any, obs_oam_addr, obs_bus_addr, src);
    end
    end_m = -1;
    for (int m = 14; m < 400; m++) begin
      idle(1);
      if (obs_dma_active !== 1'b1) begin end_m = m; break; end
    end
    n_vec++;
    if (end_m != 163) begin
      n_err++;
      $display("FAIL stall_end: got idle from M%0d want M163", end_m);
    end
    $display("test_high_stall done src=%h", src);
  endtask

  task automatic test_restart;
    logic dropped;
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'hA5);              // M0
    dropped = 1'b0;
    for (int m = 1; m < 52; m++) begin
      idle(1);
      if (m >= 1 && obs_active_low) dropped = 1'b1;
    end
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'hD0);              // M52, index 50
    if (obs_active_low) dropped = 1'b1;
    n_vec++;
    if (obs_oam_write_any !== 1'b0) begin
      n_err++;
      $display("FAIL restart_write_cycle: got ow=%b want 0", obs_oam_write_any);
    end
    idle(1);                                               // M53 Start
    if (obs_active_low) dropped = 1'b1;
    n_vec++;
    if (obs_oam_write_any !== 1'b0) begin
      n_err++;
      $display("FAIL restart_start: got ow=%b want 0", obs_oam_write_any);
    end
    idle(1);                                               // M54
    if (obs_active_low) dropped = 1'b1;
    n_vec++;
    if (obs_bus_addr !== 16'hD000 || obs_oam_addr !== 8'h00 || obs_oam_write_any !== 1'b1) begin
      n_err++;
      $display("FAIL restart_first: got addr=%h oam_addr=%h ow=%b want d000/00/1",
               obs_bus_addr, obs_oam_addr, obs_oam_write_any);
    end
    n_vec++;
    if (dropped !== 1'b0) begin
      n_err++;
      $display("FAIL restart_active_drop: got dropped=%b want 0", dropped);
    end
    idle(160);
    $display("test_restart done");
  endtask

  task automatic test_ff46_read;
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'h81);
    run_m(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);
    n_vec++;
    if (obs_rdata !== 8'h81) begin
      n_err++;
      $display("FAIL ff46_readback: got %h want 81", obs_rdata);
    end
    idle(161);
    $display("test_ff46_read done");
  endtask

  task automatic test_abort_reset;
    logic any_ow, any_act;
    run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'($urandom_range(0, 255)));
    idle(81);                                              // M1..M81, index 80 next
    run_m(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);              // reset at index 80
    any_ow = 1'b0; any_act = 1'b0;
    for (int m = 0; m < 170; m++) begin
      idle(1);
      if (obs_oam_write_any) any_ow = 1'b1;
      if (!obs_active_low) any_act = 1'b1;
    end
    n_vec++;
    if (any_ow !== 1'b0 || any_act !== 1'b0) begin
      n_err++;
      $display("FAIL abort_quiet: got ow=%b active=%b want 0/0", any_ow, any_act);
    end
    run_m(1'b0, 1'b1, 1'b0, 16'hFF46, 8'h00);
    n_vec++;
    if (obs_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL abort_ff46: got %h want 00", obs_rdata);
    end
    $display("test_abort_reset done");
  endtask

  task automatic test_random;
    int kind;
    logic [15:0] a;
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 199);
      if (kind < 2) begin
        run_m(1'b1, 1'b1, 1'b0, 16'($urandom), 8'h00);
      end else if (kind < 8) begin
        run_m(1'b0, 1'b1, 1'b1, 16'hFF46, 8'($urandom));
      end else if (kind < 70) begin
        idle(1);
      end else begin
        a = ($urandom_range(0, 3) == 0) ? {8'hFF, 8'($urandom)} : 16'($urandom);
        run_m(1'b0, 1'b1, 1'($urandom), a, 8'($urandom));
      end
    end
    $display("test_random done");
  endtask

  initial begin
    salt = 8'($urandom);
    test_reset;
    test_nominal;
    test_blocking;
    test_high_stall;
    test_restart;
    test_ff46_read;
    test_abort_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
